// File: rtl/imem_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_program_loader
// Description : Loads a program image into instruction memory from a byte
//               stream and keeps the core held in reset until the image has
//               been written and its XOR checksum verified.
//
//               Stream format: CNT_HI, CNT_LO (16-bit big-endian word count
//               N), 4*N data bytes (each word MSB first), 1 checksum byte.
//               The checksum is the XOR of every byte from CNT_HI through
//               the last data byte.
//
// Ports       : clk        - system clock, rising edge
//               rst_n      - asynchronous active-low reset
//               byte_valid - byte_data holds a valid byte
//               byte_data  - stream byte
//               byte_ready - loader accepts a byte this cycle
//               imem_we    - instruction-memory write strobe (one cycle)
//               imem_addr  - byte address of the write
//               imem_wdata - word being written
//               cpu_hold   - 1 = core held in reset
//               done       - image loaded and checksum correct
//               error      - oversize count or checksum mismatch
//
// Revision    : 1.0 - initial release
// ============================================================================
module imem_program_loader #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam logic [31:0]       MAX_WORDS_U = MAX_WORDS;
    localparam logic [ADDR_W-1:0] WORD_BYTES  = ADDR_W'(4);

    typedef enum logic [2:0] {
        S_CNT_HI = 3'd0,
        S_CNT_LO = 3'd1,
        S_WORD   = 3'd2,
        S_WRITE  = 3'd3,
        S_CHK    = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t            state_q,     state_d;
    logic [15:0]       cnt_q,       cnt_d;        // word count N
    logic [15:0]       wcnt_q,      wcnt_d;       // words written so far
    logic [1:0]        idx_q,       idx_d;        // byte index within word
    logic [7:0]        csum_q,      csum_d;       // running XOR
    logic [31:0]       asm_q,       asm_d;        // word assembly shifter
    logic [31:0]       wdata_q,     wdata_d;      // presented write data
    logic [ADDR_W-1:0] addr_q,      addr_d;       // presented write address
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;  // address of next word

    logic              w_accept;
    logic [15:0]       w_cnt_full;
    logic [15:0]       w_wcnt_inc;

    // Ready is gated by rst_n so it reads 0 for the whole reset assertion,
    // not just after the first clock.
    always_comb begin
        byte_ready = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_CNT_HI, S_CNT_LO, S_WORD, S_CHK: byte_ready = 1'b1;
                default:                           byte_ready = 1'b0;
            endcase
        end
    end

    assign w_accept   = byte_valid & byte_ready;
    assign w_cnt_full = {cnt_q[15:8], byte_data};
    assign w_wcnt_inc = wcnt_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wcnt_d      = wcnt_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        asm_d       = asm_q;
        wdata_d     = wdata_q;
        addr_d      = addr_q;
        next_addr_d = next_addr_q;

        case (state_q)
            S_CNT_HI: begin
                if (w_accept) begin
                    cnt_d[15:8] = byte_data;
                    csum_d      = csum_q ^ byte_data;
                    state_d     = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (w_accept) begin
                    cnt_d  = w_cnt_full;
                    csum_d = csum_q ^ byte_data;
                    if ({16'd0, w_cnt_full} > MAX_WORDS_U) begin
                        state_d = S_ERR;
                    end else if (w_cnt_full == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_WORD;
                    end
                end
            end
            S_WORD: begin
                if (w_accept) begin
                    csum_d = csum_q ^ byte_data;
                    asm_d  = {asm_q[23:0], byte_data};
                    idx_d  = idx_q + 2'd1;
                    // Latch the finished word and its address together so
                    // both hold steady through and after the write cycle.
                    if (idx_q == 2'd3) begin
                        wdata_d = {asm_q[23:0], byte_data};
                        addr_d  = next_addr_q;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                next_addr_d = next_addr_q + WORD_BYTES;
                wcnt_d      = w_wcnt_inc;
                state_d     = (w_wcnt_inc == cnt_q) ? S_CHK : S_WORD;
            end
            S_CHK: begin
                if (w_accept) begin
                    state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_CNT_HI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_CNT_HI;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            idx_q       <= '0;
            csum_q      <= '0;
            asm_q       <= '0;
            wdata_q     <= '0;
            addr_q      <= BASE_ADDR;
            next_addr_q <= BASE_ADDR;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            idx_q       <= idx_d;
            csum_q      <= csum_d;
            asm_q       <= asm_d;
            wdata_q     <= wdata_d;
            addr_q      <= addr_d;
            next_addr_q <= next_addr_d;
        end
    end

    assign imem_we    = (state_q == S_WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    // Released only in DONE; reset forces state back, so hold returns
    // asynchronously with rst_n.
    assign cpu_hold   = (state_q != S_DONE);

endmodule
`default_nettype wire
